// File: rtl/stack_pointer_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_pointer_unit
// Function : Full-descending stack pointer with push, pop, load and a
//            multi-word frame push, bounded to the [SP_LIMIT, SP_INIT] window.
// Revision : 1.0 - initial release
// ============================================================================
module stack_pointer_unit #(
  parameter int unsigned   W        = 16,
  parameter int unsigned   STEP     = 2,
  parameter logic [W-1:0]  SP_INIT  = 16'h0100,
  parameter logic [W-1:0]  SP_LIMIT = 16'h00F0,
  parameter int unsigned   LW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          frame_req,
  input  logic [LW-1:0] frame_len,
  input  logic          clr_flags,
  output logic [W-1:0]  sp,
  output logic [W-1:0]  mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [LW-1:0] frame_idx,
  output logic          busy,
  output logic          ovf,
  output logic          unf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PUSHING = 2'd1;

  localparam logic [W-1:0] c_step       = W'(STEP);
  localparam logic [W:0]   c_step_ext   = (W+1)'(STEP);
  localparam logic [W:0]   c_init_ext   = {1'b0, SP_INIT};
  localparam logic [W:0]   c_limit_ext  = {1'b0, SP_LIMIT};

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  logic [W-1:0]  r_sp;
  logic [W-1:0]  r_mem_addr;
  logic          r_mem_we;
  logic          r_mem_re;
  logic [LW-1:0] r_frame_idx;
  logic [LW-1:0] r_frame_last;
  logic          r_busy;
  logic          r_ovf;
  logic          r_unf;

  logic [W-1:0]  w_sp_nxt;
  logic [W-1:0]  w_mem_addr_nxt;
  logic          w_mem_we_nxt;
  logic          w_mem_re_nxt;
  logic [LW-1:0] w_frame_idx_nxt;
  logic [LW-1:0] w_frame_last_nxt;
  logic          w_busy_nxt;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;

  // Bound checks are done one bit wider so neither side can wrap.
  logic [W:0]    w_sp_ext;
  logic [W:0]    w_frame_bytes;
  logic [W-1:0]  w_sp_dec;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_frame_ok;
  logic          w_frame_nz;
  logic [LW-1:0] w_idx_inc;
  logic          w_idx_last;

  assign w_sp_ext      = {1'b0, r_sp};
  assign w_frame_bytes = (W+1)'(frame_len) * c_step_ext;
  assign w_sp_dec      = r_sp - c_step;
  assign w_push_ok     = w_sp_ext >= (c_limit_ext + c_step_ext);
  assign w_pop_ok      = (w_sp_ext + c_step_ext) <= c_init_ext;
  assign w_frame_ok    = w_sp_ext >= (c_limit_ext + w_frame_bytes);
  assign w_frame_nz    = frame_len != '0;
  assign w_idx_inc     = r_frame_idx + LW'(1);
  assign w_idx_last    = w_idx_inc == r_frame_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (!load && frame_req && w_frame_nz && w_frame_ok && (frame_len != LW'(1))) begin
          w_state_nxt = S_PUSHING;
        end
      end
      S_PUSHING: begin
        w_state_nxt = w_idx_last ? S_IDLE : S_PUSHING;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    w_sp_nxt         = r_sp;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_we_nxt     = 1'b0;
    w_mem_re_nxt     = 1'b0;
    w_frame_idx_nxt  = '0;
    w_frame_last_nxt = r_frame_last;
    w_busy_nxt       = 1'b0;
    w_ovf_nxt        = r_ovf & ~clr_flags;
    w_unf_nxt        = r_unf & ~clr_flags;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_sp_nxt = load_val;
        end else if (frame_req) begin
          if (w_frame_nz) begin
            if (w_frame_ok) begin
              w_sp_nxt         = w_sp_dec;
              w_mem_addr_nxt   = w_sp_dec;
              w_mem_we_nxt     = 1'b1;
              w_frame_last_nxt = frame_len - LW'(1);
              w_busy_nxt       = frame_len != LW'(1);
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
        end else if (push && pop) begin
          if (r_sp != SP_INIT) begin
            w_mem_addr_nxt = r_sp;
            w_mem_we_nxt   = 1'b1;
          end else begin
            w_unf_nxt = 1'b1;
          end
        end else if (push) begin
          if (w_push_ok) begin
            w_sp_nxt       = w_sp_dec;
            w_mem_addr_nxt = w_sp_dec;
            w_mem_we_nxt   = 1'b1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end else if (pop) begin
          if (w_pop_ok) begin
            w_mem_addr_nxt = r_sp;
            w_mem_re_nxt   = 1'b1;
            w_sp_nxt       = r_sp + c_step;
          end else begin
            w_unf_nxt = 1'b1;
          end
        end
      end
      S_PUSHING: begin
        // Range was prechecked on acceptance, so no bound test per word.
        w_sp_nxt        = w_sp_dec;
        w_mem_addr_nxt  = w_sp_dec;
        w_mem_we_nxt    = 1'b1;
        w_frame_idx_nxt = w_idx_inc;
        w_busy_nxt      = !w_idx_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp         <= SP_INIT;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_frame_idx  <= '0;
      r_frame_last <= '0;
      r_busy       <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      r_sp         <= w_sp_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_frame_idx  <= w_frame_idx_nxt;
      r_frame_last <= w_frame_last_nxt;
      r_busy       <= w_busy_nxt;
      r_ovf        <= w_ovf_nxt;
      r_unf        <= w_unf_nxt;
    end
  end

  assign sp        = r_sp;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign frame_idx = r_frame_idx;
  assign busy      = r_busy;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_pointer_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_pointer_unit
// Function : Directed self-checking bench for stack_pointer_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_pointer_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic        pop;
  logic        load;
  logic [15:0] load_val;
  logic        frame_req;
  logic [3:0]  frame_len;
  logic        clr_flags;
  logic [15:0] sp;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  frame_idx;
  logic        busy;
  logic        ovf;
  logic        unf;

  int checks   = 0;
  int failures = 0;

  stack_pointer_unit dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .load      (load),
    .load_val  (load_val),
    .frame_req (frame_req),
    .frame_len (frame_len),
    .clr_flags (clr_flags),
    .sp        (sp),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .frame_idx (frame_idx),
    .busy      (busy),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; load = 0; load_val = '0;
    frame_req = 0; frame_len = '0; clr_flags = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1; load_val = v;
    tick();
    load = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    check("rst_sp", sp, 32'h0100);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_idx", frame_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);

    // Single push then pop
    push = 1; tick(); push = 0;
    check("push_sp", sp, 32'h00FE);
    check("push_addr", mem_addr, 32'h00FE);
    check("push_we", mem_we, 1);
    tick();
    check("push_we_pulse", mem_we, 0);
    pop = 1; tick(); pop = 0;
    check("pop_addr", mem_addr, 32'h00FE);
    check("pop_re", mem_re, 1);
    check("pop_sp", sp, 32'h0100);
    tick();
    check("pop_re_pulse", mem_re, 0);

    // Fill to the limit, then overflow
    push = 1;
    for (int i = 0; i < 8; i++) tick();
    check("fill_sp", sp, 32'h00F0);
    check("fill_addr", mem_addr, 32'h00F0);
    tick(); push = 0;
    check("ovf_sp", sp, 32'h00F0);
    check("ovf_we", mem_we, 0);
    check("ovf_flag", ovf, 1);
    clr_flags = 1; tick(); clr_flags = 0;
    check("ovf_clr", ovf, 0);

    // Underflow and replace-top
    do_load(16'h0100);
    check("load_sp", sp, 32'h0100);
    check("load_we", mem_we, 0);
    pop = 1; tick();
    check("unf_flag", unf, 1);
    check("unf_re", mem_re, 0);
    check("unf_sp", sp, 32'h0100);
    clr_flags = 1; tick(); clr_flags = 0; pop = 0;
    check("unf_set_wins", unf, 1);
    clr_flags = 1; tick(); clr_flags = 0;
    check("unf_clr", unf, 0);
    push = 1; pop = 1; tick(); push = 0; pop = 0;
    check("rt_empty_unf", unf, 1);
    check("rt_empty_we", mem_we, 0);
    check("rt_empty_re", mem_re, 0);
    clr_flags = 1; tick(); clr_flags = 0;
    push = 1; tick();
    pop = 1; tick(); push = 0; pop = 0;
    check("rt_we", mem_we, 1);
    check("rt_re", mem_re, 0);
    check("rt_addr", mem_addr, 32'h00FE);
    check("rt_sp", sp, 32'h00FE);

    // Frame of 3 words with a push held during busy
    do_load(16'h0100);
    frame_req = 1; frame_len = 4'd3; tick(); frame_req = 0; push = 1;
    check("f0_sp", sp, 32'h00FE);
    check("f0_addr", mem_addr, 32'h00FE);
    check("f0_we", mem_we, 1);
    check("f0_idx", frame_idx, 0);
    check("f0_busy", busy, 1);
    tick();
    check("f1_addr", mem_addr, 32'h00FC);
    check("f1_idx", frame_idx, 1);
    check("f1_busy", busy, 1);
    tick(); push = 0;
    check("f2_addr", mem_addr, 32'h00FA);
    check("f2_idx", frame_idx, 2);
    check("f2_we", mem_we, 1);
    check("f2_busy", busy, 0);
    tick();
    check("f_end_sp", sp, 32'h00FA);
    check("f_end_we", mem_we, 0);
    check("f_end_ovf", ovf, 0);

    // Frame overflow precheck
    do_load(16'h00F4);
    frame_req = 1; frame_len = 4'd3; tick(); frame_req = 0;
    check("fovf_flag", ovf, 1);
    check("fovf_sp", sp, 32'h00F4);
    check("fovf_we", mem_we, 0);
    check("fovf_busy", busy, 0);
    clr_flags = 1; tick(); clr_flags = 0;
    frame_req = 1; frame_len = 4'd2; tick(); frame_req = 0;
    check("f2w_sp0", sp, 32'h00F2);
    check("f2w_busy0", busy, 1);
    tick();
    check("f2w_sp1", sp, 32'h00F0);
    check("f2w_idx1", frame_idx, 1);
    check("f2w_busy1", busy, 0);
    check("f2w_ovf", ovf, 0);

    // Reset in the middle of a frame
    do_load(16'h0100);
    pop = 1; tick(); pop = 0;
    check("pre_rst_unf", unf, 1);
    frame_req = 1; frame_len = 4'd5; tick(); frame_req = 0;
    check("fr5_sp", sp, 32'h00FE);
    check("fr5_busy", busy, 1);
    rst = 1; push = 1; tick(); rst = 0; push = 0;
    check("mrst_sp", sp, 32'h0100);
    check("mrst_busy", busy, 0);
    check("mrst_we", mem_we, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_unf", unf, 0);
    check("mrst_ovf", ovf, 0);
    tick();
    check("post_rst_sp", sp, 32'h0100);
    check("post_rst_we", mem_we, 0);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
